// File: rtl/mem_map_pkg.sv
// Address map, STATUS bit positions and small helpers shared by the
// memory responder and its FIFO.
package mem_map_pkg;

   localparam logic [7:0] RAM_TOP = 8'hEF;
   localparam logic [7:0] TXDATA  = 8'hF0;
   localparam logic [7:0] STATUS  = 8'hF1;
   localparam logic [7:0] CNT_LO  = 8'hF2;
   localparam logic [7:0] CNT_HI  = 8'hF3;

   localparam int RAM_BYTES = 240;

   localparam int ST_OVF   = 7;
   localparam int ST_FULL  = 6;
   localparam int ST_EMPTY = 5;

   // STATUS only has three count bits, so deeper FIFOs report 7.
   function automatic logic [2:0] sat_count(input int unsigned c);
      return (c > 7) ? 3'd7 : c[2:0];
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with wrap-bit pointers; the head is presented straight from
// storage registers so the consumer side never sees the producer's logic.
module byte_fifo #(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [7:0]    wdata,
   input  logic          pop,
   output logic [7:0]    rdata,
   output logic          empty,
   output logic          full,
   output logic [CW-1:0] count
);

   logic [7:0]  mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        do_push, do_pop;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count = wr_ptr_q - rd_ptr_q;

   // A pop in the same cycle frees the slot a push into a full FIFO needs.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign rdata = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/mem_responder.sv
// CPU-bus memory responder: 240 B RAM, TX byte FIFO, STATUS/overflow and a
// cycle-counter snapshot, plus a loader port that preloads RAM.
module mem_responder
   import mem_map_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] mem_address,
   input  logic       mem_wen,
   input  logic [7:0] mem_data_in,
   output logic [7:0] mem_data_out,
   input  logic       ld_en,
   input  logic [7:0] ld_addr,
   input  logic [7:0] ld_data,
   input  logic       ld_wen,
   output logic       tx_valid,
   output logic [7:0] tx_data,
   input  logic       tx_ready
);

   localparam int FCW = $clog2(FIFO_DEPTH) + 1;

   logic [7:0]       ram_q [RAM_BYTES];
   logic             overflow_q, overflow_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] snap_q, snap_d;
   logic [15:0]      snap16;
   logic [7:0]       status;

   logic             cpu_we, ld_we;
   logic             push_req, push_ok, pop;
   logic             fifo_empty, fifo_full;
   logic [FCW-1:0]   fifo_count;

   // The loader owns the bus while ld_en is high; CPU writes vanish entirely.
   assign cpu_we   = mem_wen & ~ld_en;
   assign ld_we    = ld_en & ld_wen & (ld_addr <= RAM_TOP);
   assign push_req = cpu_we && (mem_address == TXDATA);
   assign pop      = tx_valid & tx_ready;
   assign push_ok  = push_req & (~fifo_full | pop);
   assign tx_valid = ~fifo_empty;

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_ok),
      .wdata (mem_data_in),
      .pop   (pop),
      .rdata (tx_data),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (ld_we)
         ram_q[ld_addr] <= ld_data;
      else if (cpu_we && (mem_address <= RAM_TOP))
         ram_q[mem_address] <= mem_data_in;
   end

   always_comb begin
      overflow_d = overflow_q;
      cnt_d      = cnt_q + 1'b1;
      snap_d     = snap_q;
      if (cpu_we && (mem_address == STATUS))
         overflow_d = 1'b0;
      else if (push_req && !push_ok)
         overflow_d = 1'b1;
      if (cpu_we && (mem_address == CNT_LO))
         snap_d = cnt_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow_q <= 1'b0;
         cnt_q      <= '0;
         snap_q     <= '0;
      end else begin
         overflow_q <= overflow_d;
         cnt_q      <= cnt_d;
         snap_q     <= snap_d;
      end
   end

   assign snap16 = 16'(snap_q);

   always_comb begin
      status           = 8'h00;
      status[ST_OVF]   = overflow_q;
      status[ST_FULL]  = fifo_full;
      status[ST_EMPTY] = fifo_empty;
      status[2:0]      = sat_count(32'(fifo_count));
   end

   always_comb begin
      mem_data_out = 8'h00;
      case (mem_address)
         TXDATA:  mem_data_out = 8'h00;
         STATUS:  mem_data_out = status;
         CNT_LO:  mem_data_out = snap16[7:0];
         CNT_HI:  mem_data_out = snap16[15:8];
         default: if (mem_address <= RAM_TOP) mem_data_out = ram_q[mem_address];
      endcase
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: TX bytes are tracked in a scoreboard queue
// and checked against the stream; registers are checked against a small model.
module tb_mem_responder;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] mem_address, mem_data_in, mem_data_out;
   logic       mem_wen;
   logic       ld_en, ld_wen;
   logic [7:0] ld_addr, ld_data;
   logic       tx_valid, tx_ready;
   logic [7:0] tx_data;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] exp_q[$];
   logic       m_ovf;
   logic [15:0] tb_cnt;

   mem_responder #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_address  (mem_address),
      .mem_wen      (mem_wen),
      .mem_data_in  (mem_data_in),
      .mem_data_out (mem_data_out),
      .ld_en        (ld_en),
      .ld_addr      (ld_addr),
      .ld_data      (ld_data),
      .ld_wen       (ld_wen),
      .tx_valid     (tx_valid),
      .tx_data      (tx_data),
      .tx_ready     (tx_ready)
   );

   always #5 clk = ~clk;

   // Reference free-running counter, same reset and edge as the design.
   always @(posedge clk or negedge rst) begin
      if (!rst) tb_cnt <= 16'h0000;
      else      tb_cnt <= tb_cnt + 16'h0001;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic logic [7:0] exp_status();
      int unsigned n;
      n = exp_q.size();
      return {m_ovf, (n == 4), (n == 0), 2'b00, 3'(n)};
   endfunction

   // Stream side: compared at the falling edge, popped when a transfer is due.
   always @(negedge clk) begin
      chk("tx_valid", 16'(tx_valid), 16'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         chk("tx_data", 16'(tx_data), 16'(exp_q[0]));
         if (tx_ready) void'(exp_q.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
      logic acc;
      acc = 1'b0;
      mem_address = a;
      mem_data_in = d;
      mem_wen     = 1'b1;
      if (!ld_en && a == 8'hF0) begin
         acc = (exp_q.size() < 4) || (tx_ready && exp_q.size() > 0);
         if (!acc) m_ovf = 1'b1;
      end
      if (!ld_en && a == 8'hF1) m_ovf = 1'b0;
      tick();
      mem_wen = 1'b0;
      if (acc) exp_q.push_back(d);
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] expv);
      mem_address = a;
      mem_wen     = 1'b0;
      #1;
      chk(tag, 16'(mem_data_out), 16'(expv));
      $display("read  %s addr=%h data=%h", tag, a, mem_data_out);
   endtask

   task automatic wait_cnt(input logic [15:0] target);
      int guard;
      guard = 0;
      while (tb_cnt != target && guard < 70000) begin
         tick();
         guard++;
      end
      chk("cnt_wait_bound", 16'(guard < 70000), 16'd1);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      tx_ready = 1'b1;
      while (exp_q.size() != 0 && guard < 20) begin
         tick();
         guard++;
      end
      chk("drain_bound", 16'(guard < 20), 16'd1);
   endtask

   initial begin
      rst = 1'b0; m_ovf = 1'b0;
      mem_address = 8'h00; mem_data_in = 8'h00; mem_wen = 1'b0;
      ld_en = 1'b0; ld_wen = 1'b0; ld_addr = 8'h00; ld_data = 8'h00;
      tx_ready = 1'b0;
      #2;
      chk("reset_tx_valid", 16'(tx_valid), 16'd0);
      chk("reset_tx_data", 16'(tx_data), 16'h00);
      rd_chk("reset_status", 8'hF1, 8'h20);
      rd_chk("reset_cnt_lo", 8'hF2, 8'h00);
      rd_chk("reset_cnt_hi", 8'hF3, 8'h00);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // Loader preload; its write to 0xF0 and a CPU write to 0xF0 must not reach the FIFO.
      ld_en = 1'b1; ld_wen = 1'b1; ld_addr = 8'h10; ld_data = 8'hA5;
      tick();
      ld_addr = 8'hF0; ld_data = 8'h55;
      tick();
      ld_wen = 1'b0;
      cpu_wr(8'hF0, 8'h77);
      cpu_wr(8'h10, 8'h3C);
      $display("load  0x10<-A5, 0xF0<-55 (ignored), cpu 0xF0/0x10 during ld_en dropped");
      chk("ld_tx_valid", 16'(tx_valid), 16'd0);
      rd_chk("ld_status", 8'hF1, 8'h20);
      ld_en = 1'b0;
      rd_chk("ram_10", 8'h10, 8'hA5);

      // Stalled sink: five pushes into a 4-deep FIFO.
      tx_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         cpu_wr(8'hF0, 8'(i));
         $display("push  %h accepted_so_far=%0d", i, exp_q.size());
      end
      rd_chk("status_ovf_full", 8'hF1, 8'hC4);
      rd_chk("status_model_a", 8'hF1, exp_status());
      tick(); tick();
      chk("stall_hold", 16'(tx_data), 16'h01);
      cpu_wr(8'hF1, 8'h00);
      rd_chk("status_clr", 8'hF1, 8'h44);
      drain();

      // Back-to-back pushes into an empty FIFO with the sink ready.
      cpu_wr(8'hF0, 8'h01);
      cpu_wr(8'hF0, 8'h02);
      cpu_wr(8'hF0, 8'h03);
      $display("push  01 02 03 with tx_ready=1");
      tick(); tick();
      rd_chk("status_empty", 8'hF1, 8'h20);

      // Push into a full FIFO while popping: accepted, no overflow.
      tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) cpu_wr(8'hF0, 8'(8'h11 + i));
      rd_chk("full_again", 8'hF1, 8'h44);
      tx_ready = 1'b1;
      cpu_wr(8'hF0, 8'h99);
      $display("push  99 into full FIFO while popping");
      rd_chk("full_push_pop", 8'hF1, 8'h44);
      drain();
      rd_chk("after_99", 8'hF1, 8'h20);

      // Counter snapshot and wrap.
      wait_cnt(16'h0123);
      cpu_wr(8'hF2, 8'h00);
      tick();
      rd_chk("snap_lo", 8'hF2, 8'h23);
      rd_chk("snap_hi", 8'hF3, 8'h01);
      wait_cnt(16'hFFFF);
      cpu_wr(8'hF2, 8'h00);
      rd_chk("snap_ffff_lo", 8'hF2, 8'hFF);
      rd_chk("snap_ffff_hi", 8'hF3, 8'hFF);
      cpu_wr(8'hF2, 8'h00);
      rd_chk("snap_wrap_lo", 8'hF2, 8'h00);
      rd_chk("snap_wrap_hi", 8'hF3, 8'h00);

      // Asynchronous reset with bytes queued.
      tx_ready = 1'b0;
      cpu_wr(8'hF0, 8'hB1);
      cpu_wr(8'hF0, 8'hB2);
      cpu_wr(8'hF0, 8'hB3);
      #1;
      rst = 1'b0;
      exp_q.delete();
      m_ovf = 1'b0;
      #1;
      chk("rst_tx_valid", 16'(tx_valid), 16'd0);
      chk("rst_tx_data", 16'(tx_data), 16'h00);
      rd_chk("rst_status", 8'hF1, 8'h20);
      rd_chk("rst_ram_10", 8'h10, 8'hA5);
      $display("reset asserted mid-stream with 3 bytes queued");
      @(negedge clk);
      rst = 1'b1;
      tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
